spi_master: RTL
===============

# spi_master

SPI bus master (mode 0, MSB first, 8-bit frames) with a TX FIFO for bytes to send and an RX FIFO for bytes clocked in on MISO. It is the initiator for the `spi_slave` on the far end of the link. It lets a design drive a second board, or loop back into its own `spi_slave` for self-test. The FIFO handshakes match the UART FIFO ports, so top-level glue can move bytes between UART, SPI slave and SPI master uniformly.

## Interface
- `CLOCK_FREQUENCY`, 27000000, system clock in Hz.
- `SPI_FREQUENCY`, 1000000, target SCK rate. Half period H = CLOCK_FREQUENCY/(2*SPI_FREQUENCY), integer division; H is 13 at defaults and must be ≥ 1.
- `FIFO_DEPTH`, 16, entries per FIFO; must be a power of 2.
- `CS_IDLE_CYCLES`, 27, minimum clocks CS stays high between bursts; must be ≥ 1.
- `clock` in 1: system clock. All logic is single-clock and updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `tx_fifo_data_in` in 8: byte to send.
- `tx_fifo_write_en` in 1: push `tx_fifo_data_in` to the TX FIFO. Ignored when full.
- `tx_fifo_full` out 1: TX FIFO full.
- `rx_fifo_data_out` out 8: head of the RX FIFO, first-word fall-through; valid whenever not empty.
- `rx_fifo_read_en` in 1: pop the RX head. Ignored when empty.
- `rx_fifo_empty` out 1: RX FIFO empty.
- `rx_overflow` out 1: one-cycle pulse when a received byte is dropped because the RX FIFO is full.
- `busy` out 1: high whenever the state is not IDLE.
- `spi_clk` out 1: SCK, registered, idle low.
- `spi_cs` out 1: chip select, active low, registered.
- `mosi` out 1: registered.
- `miso` in 1: from slave. Sampled directly, with no synchroniser.

## Operation
- Reset values:
  - `spi_cs`=1, `spi_clk`=0, `mosi`=0, `busy`=0, `rx_overflow`=0.
  - `tx_fifo_full`=0, `rx_fifo_empty`=1, `rx_fifo_data_out`=0.
  - Both FIFOs are cleared and the state is IDLE.
- FIFOs are circular buffers with log2(FIFO_DEPTH) pointers that wrap, plus a count of width log2(FIFO_DEPTH)+1. A simultaneous push and pop in the same cycle both take effect and leave the count unchanged; this includes a push while full if a pop happens the same cycle.
- A half-period counter runs in every state except IDLE. A "tick" means H cycles have elapsed in the current state; the counter reloads on every state change.
- States:
  - IDLE: `spi_cs`=1, `spi_clk`=0, `mosi`=0. If the TX FIFO is not empty: pop into the shift register, set `spi_cs`←0, `mosi`←bit7, bit_cnt←0, then go to LEAD.
  - LEAD: on tick, `spi_clk`←1 and shift `miso` into the RX shift register (LSB side); go to HIGH.
  - HIGH: on tick, `spi_clk`←0, then:
    - If bit_cnt<7: `mosi`←next bit, bit_cnt+1, go to LOW.
    - Else the byte is complete. Push the RX byte to the RX FIFO, or pulse `rx_overflow` if it is full. Then, if the TX FIFO is not empty, pop it, set `mosi`←bit7, bit_cnt←0 and go to LOW, keeping CS low (continuous burst). Otherwise go to TRAIL.
  - LOW: on tick, `spi_clk`←1 and sample `miso`; go to HIGH.
  - TRAIL: on tick, `spi_cs`←1, `mosi`←0; go to GAP.
  - GAP: after CS_IDLE_CYCLES cycles, go to IDLE.
- Whether a burst continues is decided only at the byte-complete edge. Bytes pushed during TRAIL or GAP start a new CS frame.
- `reset` asserted mid-transfer: on the next edge CS goes high and SCK low. The partial byte is discarded and nothing is pushed.

## Timing
- Let t0 be the edge at which IDLE pops a byte.
  - CS falls and MOSI shows bit7 at t0.
  - SCK rises at t0+H+2kH for k=0..7; MISO is sampled on those same edges.
  - SCK falls at t0+2H+2kH.
  - The last fall is at t0+16H. The RX push happens on that edge, so `rx_fifo_empty` reads 0 from t0+16H+1.
- Back-to-back bytes take exactly 16H cycles each, with no SCK gap and no CS pulse between them.
- CS rises at t0+16H·n+H for an n-byte burst. `busy` falls CS_IDLE_CYCLES cycles after CS rises.
- Latency from a TX write (FIFO previously empty, state IDLE) to CS fall is 2 cycles: the push is registered, then IDLE sees the FIFO non-empty.
- MOSI changes only on SCK-falling edges or at CS fall, so it is stable for H cycles before each rising edge.

## Test plan
- Single byte at H=13: write 0xA5 while the slave model returns 0x3C. Check CS is low for 17H=221 cycles and MOSI bits are 1,0,1,0,0,1,0,1 at the rising edges. Check RX head = 0x3C, `rx_fifo_empty`=0 at t0+209, and `busy` drops 27 cycles after CS rises.
- Burst: write 0x01, 0x02, 0x03 on consecutive cycles. Check a single CS frame of 48H+H cycles, RX receives the 3 echo bytes in order, and SCK has 24 rising edges.
- TX full: write 17 bytes with no SPI progress possible (hold `reset` low, write in one burst, first byte already popped). Check `tx_fifo_full` asserts, that the 18th write is dropped, and that exactly 17 bytes are transmitted.
- RX overflow: send 17 bytes without reading. Check the 17th completion pulses `rx_overflow` for 1 cycle, and that the RX FIFO then holds the first 16 bytes unchanged.
- Reset mid-byte: assert `reset` at t0+5H. Check CS=1, SCK=0, MOSI=0 on the next edge, RX stays empty, and both FIFOs read empty/not-full.
- Simultaneous RX pop and push at the byte-complete edge with 16 entries held: check no overflow pulse, count stays 16, and the new byte becomes the tail.

Source files
------------

// File: rtl/spi_master.sv
// Generic synchronous FIFO: registered push/pop, first-word fall-through read port.
// Latency: a pushed word is visible at rd_dat the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = rd_rdy && !empty;
  // A pop frees the slot being written, so a full FIFO still accepts a same-cycle push.
  assign do_push = wr_vld && (!full || do_pop);
  assign rd_dat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// SPI mode-0 master, MSB first, 8-bit frames, with TX and RX byte FIFOs.
// Latency: CS falls 2 cycles after a write into an idle empty TX FIFO; each byte takes 16 half-periods.
// Backpressure: TX writes dropped when full; RX bytes dropped with a one-cycle rx_overflow when RX is full.
module spi_master #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int SPI_FREQUENCY   = 1000000,
  parameter int FIFO_DEPTH      = 16,
  parameter int CS_IDLE_CYCLES  = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_fifo_data_in,
  input  logic       tx_fifo_write_en,
  output logic       tx_fifo_full,
  output logic [7:0] rx_fifo_data_out,
  input  logic       rx_fifo_read_en,
  output logic       rx_fifo_empty,
  output logic       rx_overflow,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       mosi,
  input  logic       miso
);
  localparam int HALF    = CLOCK_FREQUENCY / (2 * SPI_FREQUENCY);
  localparam int CNT_MAX = (HALF > CS_IDLE_CYCLES) ? HALF : CS_IDLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_IDLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [6:0]  tx_sr, tx_sr_nxt;
  logic [7:0]  rx_sr, rx_sr_nxt;
  logic        cs_nxt, sck_nxt, mosi_nxt, ovf_nxt;
  logic        tick;
  logic        tx_pop, tx_empty;
  logic [7:0]  tx_head;
  logic        rx_push, rx_full;

  fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_vld (tx_fifo_write_en),
    .wr_dat (tx_fifo_data_in),
    .full   (tx_fifo_full),
    .rd_rdy (tx_pop),
    .rd_dat (tx_head),
    .empty  (tx_empty)
  );

  fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_vld (rx_push),
    .wr_dat (rx_sr),
    .full   (rx_full),
    .rd_rdy (rx_fifo_read_en),
    .rd_dat (rx_fifo_data_out),
    .empty  (rx_fifo_empty)
  );

  assign busy = (state != IDLE);
  assign tick = (cnt == HALF_LAST);

  always_comb begin
    state_nxt   = state;
    cs_nxt      = spi_cs;
    sck_nxt     = spi_clk;
    mosi_nxt    = mosi;
    bit_cnt_nxt = bit_cnt;
    tx_sr_nxt   = tx_sr;
    rx_sr_nxt   = rx_sr;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    ovf_nxt     = 1'b0;
    case (state)
      IDLE: begin
        cs_nxt   = 1'b1;
        sck_nxt  = 1'b0;
        mosi_nxt = 1'b0;
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_sr_nxt   = tx_head[6:0];
          mosi_nxt    = tx_head[7];
          cs_nxt      = 1'b0;
          bit_cnt_nxt = 3'd0;
          state_nxt   = LEAD;
        end
      end
      LEAD, LOW: begin
        if (tick) begin
          sck_nxt   = 1'b1;
          rx_sr_nxt = {rx_sr[6:0], miso};
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sck_nxt = 1'b0;
          if (bit_cnt != 3'd7) begin
            mosi_nxt    = tx_sr[6];
            tx_sr_nxt   = {tx_sr[5:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 3'd1;
            state_nxt   = LOW;
          end else begin
            if (rx_full && !rx_fifo_read_en) ovf_nxt = 1'b1;
            else                             rx_push = 1'b1;
            // Burst continuation is decided only here, on the byte-complete edge.
            if (!tx_empty) begin
              tx_pop      = 1'b1;
              tx_sr_nxt   = tx_head[6:0];
              mosi_nxt    = tx_head[7];
              bit_cnt_nxt = 3'd0;
              state_nxt   = LOW;
            end else begin
              state_nxt = TRAIL;
            end
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_nxt    = 1'b1;
          mosi_nxt  = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt != state || state == IDLE) ? '0 : cnt + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= 3'd0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      spi_cs      <= 1'b1;
      spi_clk     <= 1'b0;
      mosi        <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      tx_sr       <= tx_sr_nxt;
      rx_sr       <= rx_sr_nxt;
      spi_cs      <= cs_nxt;
      spi_clk     <= sck_nxt;
      mosi        <= mosi_nxt;
      rx_overflow <= ovf_nxt;
    end
  end
endmodule
